// File: rtl/ccu_pkg.sv
// ccu_pkg: shared frame constants for the count-frame link (header, field order, FSM encoding)
package ccu_pkg;
    localparam logic [7:0] HEADER_BYTE = 8'd47;
    localparam int N_FIELDS = 9;
    localparam int IDX_A    = 0;
    localparam int IDX_B    = 1;
    localparam int IDX_BP   = 2;
    localparam int IDX_AP   = 3;
    localparam int IDX_AB   = 4;
    localparam int IDX_ABP  = 5;
    localparam int IDX_APB  = 6;
    localparam int IDX_APBP = 7;
    localparam int IDX_ABBP = 8;
    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;
endpackage

// File: rtl/ccu_byte_timeout.sv
// ccu_byte_timeout: idle-cycle counter that flags a stalled frame after TIMEOUT_CYCLES quiet cycles
module ccu_byte_timeout #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] r_cnt;

    // A byte arriving in the expiry cycle clears the counter instead of expiring
    assign o_expire = i_en && !i_clr && (r_cnt == W'(TIMEOUT_CYCLES - 1));

    // Count quiet cycles only while a frame is being received
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else if (i_clr || !i_en) r_cnt <= '0;
        else if (!o_expire) r_cnt <= r_cnt + W'(1);
    end
endmodule

// File: rtl/count_frame_decoder.sv
// count_frame_decoder: hunts for the header byte, collects the payload and publishes it atomically
module count_frame_decoder
    import ccu_pkg::*;
#(
    parameter logic [7:0] HEADER         = ccu_pkg::HEADER_BYTE,
    parameter int         N_FIELDS       = ccu_pkg::N_FIELDS,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  a,
    output logic [7:0]  b,
    output logic [7:0]  bp,
    output logic [7:0]  ap,
    output logic [7:0]  ab,
    output logic [7:0]  abp,
    output logic [7:0]  apb,
    output logic [7:0]  apbp,
    output logic [7:0]  abbp,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        busy,
    output logic [15:0] frame_cnt
);
    localparam int IW = $clog2(N_FIELDS);

    logic [0:0]    r_state;
    logic [IW-1:0] r_idx;
    logic [7:0]    r_shadow [0:N_FIELDS-2];
    logic [7:0]    r_field  [0:N_FIELDS-1];
    logic          r_frame_valid;
    logic          r_frame_err;
    logic [15:0]   r_frame_cnt;
    logic          w_expire;
    logic          w_last;

    assign w_last      = (r_idx == IW'(N_FIELDS - 1));
    assign busy        = (r_state == ST_RECV);
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign frame_cnt   = r_frame_cnt;
    assign a           = r_field[IDX_A];
    assign b           = r_field[IDX_B];
    assign bp          = r_field[IDX_BP];
    assign ap          = r_field[IDX_AP];
    assign ab          = r_field[IDX_AB];
    assign abp         = r_field[IDX_ABP];
    assign apb         = r_field[IDX_APB];
    assign apbp        = r_field[IDX_APBP];
    assign abbp        = r_field[IDX_ABBP];

    ccu_byte_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (rx_valid),
        .i_en     (busy),
        .o_expire (w_expire)
    );

    // Shadow holds payload bytes 0..N-2; the final byte goes straight to the outputs
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_FIELDS - 1; i++)
            if (busy && rx_valid && r_idx == IW'(i)) r_shadow[i] <= rx_data;
    end

    // Frame FSM: header sync, payload indexing, atomic publish and timeout abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_HUNT;
            r_idx         <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_cnt   <= '0;
            for (int i = 0; i < N_FIELDS; i++) r_field[i] <= '0;
        end else begin
            r_frame_valid <= 1'b0;
            r_frame_err   <= w_expire;
            if (r_state == ST_HUNT) begin
                if (rx_valid && rx_data == HEADER) begin
                    r_state <= ST_RECV;
                    r_idx   <= '0;
                end
            end else if (rx_valid) begin
                if (w_last) begin
                    for (int i = 0; i < N_FIELDS - 1; i++) r_field[i] <= r_shadow[i];
                    r_field[N_FIELDS-1] <= rx_data;
                    r_frame_valid       <= 1'b1;
                    r_frame_cnt         <= r_frame_cnt + 16'd1;
                    r_state             <= ST_HUNT;
                    r_idx               <= '0;
                end else begin
                    r_idx <= r_idx + IW'(1);
                end
            end else if (w_expire) begin
                r_state <= ST_HUNT;
                r_idx   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_count_frame_decoder.sv
// tb_count_frame_decoder: randomized scoreboard bench with a queue-based frame reference model
module tb_count_frame_decoder;
    localparam int         T = 20;
    localparam logic [7:0] H = 8'd47;

    typedef struct packed {
        logic            err;
        logic [31:0]     due;
        logic [8:0][7:0] f;
        logic [15:0]     cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic [7:0]  a, b, bp, ap, ab, abp, apb, apbp, abbp;
    logic        frame_valid, frame_err, busy;
    logic [15:0] frame_cnt;
    logic [8:0][7:0] w_f;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit              m_recv = 1'b0;
    logic [7:0]      m_buf[$];
    int              m_last = 0;
    logic [15:0]     m_cnt = '0;
    logic [8:0][7:0] m_out = '0;
    exp_t            q[$];
    logic [8:0][7:0] cur_out = '0;
    logic [15:0]     cur_cnt = '0;

    assign w_f = {abbp, apbp, apb, abp, ab, ap, bp, b, a};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    count_frame_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .a(a), .b(b), .bp(bp), .ap(ap), .ab(ab), .abp(abp), .apb(apb), .apbp(apbp), .abbp(abbp),
        .frame_valid(frame_valid), .frame_err(frame_err), .busy(busy), .frame_cnt(frame_cnt)
    );

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock of stimulus; the model decides what the edge that samples it must produce
    task automatic step(input bit v, input logic [7:0] d);
        int s;
        @(negedge clk);
        chk("busy", busy, m_recv);
        rx_valid = v;
        rx_data  = d;
        s = cyc + 1;
        if (!m_recv) begin
            if (v && d == H) begin
                m_recv = 1'b1;
                m_buf.delete();
                m_last = s;
            end
        end else if (v) begin
            m_buf.push_back(d);
            m_last = s;
            if (m_buf.size() == 9) begin
                m_cnt++;
                for (int i = 0; i < 9; i++) m_out[i] = m_buf[i];
                q.push_back('{err: 1'b0, due: s, f: m_out, cnt: m_cnt});
                m_recv = 1'b0;
            end
        end else if (s - m_last == T) begin
            q.push_back('{err: 1'b1, due: s, f: m_out, cnt: m_cnt});
            m_recv = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'($urandom));
    endtask

    task automatic send_frame(input logic [8:0][7:0] p, input int max_gap);
        step(1'b1, H);
        for (int i = 0; i < 9; i++) begin
            idle($urandom_range(0, max_gap));
            step(1'b1, p[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        #1;
        chk("reset_fields", w_f, 72'd0);
        chk("reset_cnt", frame_cnt, 16'd0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_fv", frame_valid, 1'b0);
        chk("reset_fe", frame_err, 1'b0);
        m_recv  = 1'b0;
        m_out   = '0;
        m_cnt   = '0;
        cur_out = '0;
        cur_cnt = '0;
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard on every pulse, otherwise checks outputs hold
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("exclusive", frame_valid & frame_err, 1'b0);
                if (frame_valid || frame_err) begin
                    if (q.size() == 0) begin
                        chk("unexpected_pulse", {frame_valid, frame_err}, 2'b00);
                    end else begin
                        e = q.pop_front();
                        chk("pulse_kind", {frame_valid, frame_err}, e.err ? 2'b01 : 2'b10);
                        chk("latency", cyc, e.due);
                        chk("fields", w_f, e.f);
                        chk("frame_cnt", frame_cnt, e.cnt);
                        cur_out = e.f;
                        cur_cnt = e.cnt;
                    end
                end else begin
                    chk("hold_fields", w_f, cur_out);
                    chk("hold_cnt", frame_cnt, cur_cnt);
                    if (q.size() != 0 && int'(q[0].due) <= cyc) begin
                        chk("missing_pulse", {frame_valid, frame_err}, q[0].err ? 2'b01 : 2'b10);
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [8:0][7:0] p;
        do_reset();
        for (int i = 0; i < 9; i++) p[i] = 8'(i + 1);
        send_frame(p, 0);
        idle(3);
        step(1'b1, 8'h10);
        step(1'b1, 8'h55);
        for (int i = 0; i < 9; i++) p[i] = 8'(8'h21 + i);
        send_frame(p, 0);
        idle(2);
        send_frame({9{H}}, 0);
        idle(2);
        step(1'b1, H);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i));
        idle(T + 3);
        for (int i = 0; i < 9; i++) p[i] = 8'(8'h70 + i);
        send_frame(p, 0);
        step(1'b1, H);
        step(1'b1, 8'h01);
        idle(T - 1);
        step(1'b1, 8'h02);
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h80 + i));
        for (int i = 0; i < 9; i++) p[i] = 8'(8'h90 + i);
        send_frame(p, 0);
        for (int i = 0; i < 9; i++) p[i] = 8'(8'hA0 + i);
        send_frame(p, 0);
        idle(3);
        step(1'b1, H);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hB0 + i));
        idle(1);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hB5 + i));
        for (int i = 0; i < 9; i++) p[i] = 8'(8'hC0 + i);
        send_frame(p, 1);
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1: step(1'b1, 8'($urandom));
                2: idle($urandom_range(T - 1, T + 1));
                3: begin
                    step(1'b1, H);
                    repeat ($urandom_range(1, 8)) step(1'b1, 8'($urandom));
                end
                default: begin
                    for (int i = 0; i < 9; i++) p[i] = ($urandom_range(0, 4) == 0) ? H : 8'($urandom);
                    send_frame(p, $urandom_range(0, 1) ? 0 : 3);
                end
            endcase
        end
        idle(T + 5);
        chk("drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/count_frame_decoder.md
COUNT_FRAME_DECODER -- requirements
Module: count_frame_decoder

Interface
REQ-001 Parameter HEADER, default 8'd47, frame sync byte.
REQ-002 Parameter N_FIELDS, default 9, payload bytes per frame.
REQ-003 Parameter TIMEOUT_CYCLES, default 100000, max idle clk cycles between payload bytes.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 rx_data  input  8  received byte, valid only when rx_valid=1.
REQ-007 rx_valid  input  1  one-cycle strobe per received byte.
REQ-008 a, b, bp, ap, ab, abp, apb, apbp, abbp  output  8 each  registered count fields, payload order 0..8.
REQ-009 frame_valid  output  1  one-cycle pulse, new complete frame on field outputs.
REQ-010 frame_err  output  1  one-cycle pulse, partial frame discarded on timeout.
REQ-011 busy  output  1  high while in RECV.
REQ-012 frame_cnt  output  16  count of good frames, wraps 16'hFFFF -> 0.

Function
REQ-013 FSM states SHALL be HUNT and RECV only.
REQ-014 HUNT: rx_valid with rx_data==HEADER -> RECV, byte index cleared to 0; any other byte discarded, stay HUNT.
REQ-015 RECV: each rx_valid byte SHALL be written to shadow[index], then index increments.
REQ-016 RECV: payload byte equal to HEADER SHALL be treated as data, no resync, no escaping.
REQ-017 On the edge sampling payload byte N_FIELDS-1, all nine outputs SHALL load atomically (shadow 0..7 plus current byte), frame_valid=1 for the following cycle, frame_cnt increments, FSM -> HUNT.
REQ-018 Latency: outputs and frame_valid visible exactly 1 cycle after the last payload byte's rx_valid cycle.
REQ-019 Field outputs SHALL hold the last good frame until the next good frame; never partially updated.
REQ-020 Timeout counter SHALL clear on entry to RECV and on every rx_valid in RECV, increment each other RECV cycle.
REQ-021 Counter reaching TIMEOUT_CYCLES-1 without rx_valid: frame_err=1 next cycle, shadow discarded, FSM -> HUNT, outputs and frame_cnt unchanged.
REQ-022 rx_valid on the same cycle as timeout expiry: byte wins, no frame_err.
REQ-023 Header arriving in the cycle frame_valid is high SHALL be accepted (back-to-back frames, zero gap).
REQ-024 frame_valid and frame_err SHALL never be high simultaneously.
REQ-025 rx_valid=0 cycles SHALL not advance index; rx_data ignored.

Reset
REQ-026 rst_n low SHALL asynchronously force: FSM=HUNT, index=0, timeout counter=0, all field outputs=8'd0, frame_valid=0, frame_err=0, busy=0, frame_cnt=0.
REQ-027 Reset mid-frame SHALL drop the partial frame; first byte after release is treated as HUNT input.
REQ-028 Reset release SHALL be synchronized externally; block samples normally from the first clk edge after deassertion.

Structure
REQ-029 Shared package ccu_pkg SHALL hold HEADER_BYTE=8'd47, N_FIELDS=9, field index constants (IDX_A=0 .. IDX_ABBP=8), FSM state encoding.
REQ-030 Field order and header value SHALL match the transmitter's out-going sequence via ccu_pkg only; no local literals.
REQ-031 One sub-module ccu_byte_timeout (counter, clear, enable, expire pulse) SHALL implement REQ-020/021.
REQ-032 Shadow storage SHALL be a register array of N_FIELDS-1 bytes; no memory inference required.

Verification
REQ-033 Reset, then bytes 47,1,2,3,4,5,6,7,8,9 back-to-back -> a=1..abbp=9, frame_valid pulse 1 cycle after byte 9, frame_cnt=1.
REQ-034 Bytes 0x10,0x2F(47),... prefix garbage 0x10,0x55 then valid frame -> garbage ignored, frame decoded as REQ-033.
REQ-035 Frame with payload 47,47,...,47 -> all outputs=47, no resync, frame_valid once.
REQ-036 Header plus 4 bytes then silence TIMEOUT_CYCLES -> frame_err pulse, outputs keep previous frame, busy falls; next full frame decodes correctly.
REQ-037 Two frames zero-gap, second header in frame_valid cycle -> two frame_valid pulses, frame_cnt=2, second values on outputs.
REQ-038 rst_n pulsed low after byte 5 of a frame -> all outputs 0, FSM HUNT; remaining 4 bytes ignored until next 47.
